cpu_clk_sched: RTL and testbench

Clock-enable scheduler for the single-cycle CPU on the board. It runs from the 100 MHz board clock and issues one-cycle `cpu_ce` pulses, replacing a free-running divided clock as the CPU's step source. It supports free-run at four selectable rates, halt, and debounced single-step from a pushbutton. It also honours halt requests from the CPU (break/syscall) and counts issued CPU cycles for the 7-segment display.

---
 rtl/cpu_clk_sched.sv | 162 ++++++++++++++++
 tb/tb_cpu_clk_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_sched.sv
// cpu_clk_sched: clock-enable scheduler for the single-cycle CPU.
// Issues one-cycle cpu_ce pulses in free-run (four rates) or debounced
// single-step, honours CPU halt requests and counts issued CPU cycles.
//
// state  | meaning
// S_HALT | no pulses; waits for run switch (unlocked) or a step press
// S_RUN  | free-run, pulse every DIV[sel_s]+1 cycles
// S_STEP | single cycle in which the step pulse is high
module cpu_clk_sched #(
  parameter int DIV0       = 0,
  parameter int DIV1       = 99,
  parameter int DIV2       = 99_999,
  parameter int DIV3       = 49_999_999,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic [1:0]  speed_sel,
  input  logic        halt_req,
  output logic        cpu_ce,
  output logic [1:0]  mode,
  output logic [31:0] cycle_cnt
);

  localparam int MAX01 = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int MAX23 = (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int MAXD  = (MAX01 > MAX23) ? MAX01 : MAX23;
  localparam int TW    = (MAXD > 0) ? $clog2(MAXD + 1) : 1;
  localparam int DW    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10
  } state_t;

  state_t          state, state_nx;
  logic            run_meta, run_s;
  logic            btn_meta, btn_s;
  logic [1:0]      sel_meta, sel_s;
  logic            btn_d;
  logic [DW-1:0]   deb_cnt;
  logic            step_evt;
  logic            halt_lock;
  logic [TW-1:0]   tick, tick_nx;
  logic [TW-1:0]   limit;
  logic            ce_nx;

  // two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_meta <= 1'b0;
      run_s    <= 1'b0;
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      sel_meta <= 2'b00;
      sel_s    <= 2'b00;
    end else begin
      run_meta <= run_sw;
      run_s    <= run_meta;
      btn_meta <= step_btn;
      btn_s    <= btn_meta;
      sel_meta <= speed_sel;
      sel_s    <= sel_meta;
    end
  end

  // debounce: flip btn_d after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_d    <= 1'b0;
      deb_cnt  <= '0;
      step_evt <= 1'b0;
    end else begin
      step_evt <= 1'b0;
      if (btn_s == btn_d) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
        deb_cnt  <= '0;
        btn_d    <= btn_s;
        step_evt <= btn_s;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // halt lock: a CPU halt sticks until the run switch has been turned off
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halt_lock <= 1'b0;
    end else if (halt_req) begin
      halt_lock <= 1'b1;
    end else if (!run_s) begin
      halt_lock <= 1'b0;
    end
  end

  // period limit for the currently synchronised speed select
  always_comb begin
    limit = TW'(DIV0);
    case (sel_s)
      2'd0: limit = TW'(DIV0);
      2'd1: limit = TW'(DIV1);
      2'd2: limit = TW'(DIV2);
      2'd3: limit = TW'(DIV3);
      default: limit = TW'(DIV0);
    endcase
  end

  // next-state, next pulse and tick update
  always_comb begin
    state_nx = state;
    ce_nx    = 1'b0;
    tick_nx  = tick;
    case (state)
      S_HALT: begin
        if (run_s && !halt_lock) begin
          state_nx = S_RUN;
          tick_nx  = '0;
        end else if (step_evt) begin
          state_nx = S_STEP;
          ce_nx    = 1'b1;
        end
      end
      S_RUN: begin
        if (halt_req || !run_s) begin
          state_nx = S_HALT;
        end else if (tick >= limit) begin
          ce_nx   = 1'b1;
          tick_nx = '0;
        end else begin
          tick_nx = tick + TW'(1);
        end
      end
      S_STEP: state_nx = S_HALT;
      default: state_nx = S_HALT;
    endcase
  end

  // state, pulse, tick and issued-cycle counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_HALT;
      cpu_ce    <= 1'b0;
      tick      <= '0;
      cycle_cnt <= '0;
    end else begin
      state  <= state_nx;
      cpu_ce <= ce_nx;
      tick   <= tick_nx;
      if (cpu_ce) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_cpu_clk_sched.sv
module tb_cpu_clk_sched;

  localparam int DEB = 4;

  logic        clk;
  logic        rst_n;
  logic        run_sw;
  logic        step_btn;
  logic [1:0]  speed_sel;
  logic        halt_req;
  logic        cpu_ce;
  logic [1:0]  mode;
  logic [31:0] cycle_cnt;

  typedef struct {
    int          t;
    logic [31:0] cnt;
    logic [1:0]  m;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt;

  cpu_clk_sched #(
    .DIV0(0), .DIV1(3), .DIV2(5), .DIV3(7), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_sw(run_sw), .step_btn(step_btn),
    .speed_sel(speed_sel), .halt_req(halt_req), .cpu_ce(cpu_ce),
    .mode(mode), .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic int div_of(input int sel);
    case (sel)
      0: return 0;
      1: return 3;
      2: return 5;
      default: return 7;
    endcase
  endfunction

  // expected pulse at edge t; the count shown is the number of earlier pulses
  task automatic push(input int t, input logic [1:0] m);
    exp_t e;
    e.t = t;
    e.cnt = exp_cnt;
    e.m = m;
    q.push_back(e);
    exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // monitor: every observed pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (cpu_ce === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse at cycle %0d: got pulse expected none", cyc);
      end else begin
        mon_e = q.pop_front();
        check("pulse_time", 32'(cyc), 32'(mon_e.t));
        check("pulse_cnt", cycle_cnt, mon_e.cnt);
        check("pulse_mode", 32'(mode), 32'(mon_e.m));
      end
    end
  end

  // free-run for L cycles at select sel; pulses land at entry + k*(D+1)
  task automatic run_seg(input int sel, input int len);
    int c, e, d;
    c = cyc;
    e = c + 3;
    d = div_of(sel);
    for (int t = e + d + 1; t <= c + len + 2; t += d + 1) push(t, 2'b01);
    run_sw = 1'b1;
    speed_sel = 2'(sel);
    wait_until(c + 2);
    check("run_pre_mode", 32'(mode), 32'd0);
    wait_until(c + 3);
    check("run_entry_mode", 32'(mode), 32'd1);
    wait_until(c + len);
    run_sw = 1'b0;
    wait_until(c + len + 3);
    check("run_exit_mode", 32'(mode), 32'd0);
    wait_until(c + len + 5);
    check("cnt_after_run", cycle_cnt, exp_cnt);
  endtask

  // bounce (segments shorter than DEB), then a clean press held 10 cycles
  task automatic step_seg(input int blen);
    int r1, r2, tc;
    r1 = (blen > 0) ? blen : $urandom_range(1, DEB - 1);
    r2 = (blen > 0) ? blen : $urandom_range(1, DEB - 1);
    step_btn = 1'b1;
    repeat (r1) @(negedge clk);
    step_btn = 1'b0;
    repeat (r2) @(negedge clk);
    tc = cyc;
    push(tc + 3 + DEB, 2'b10);
    step_btn = 1'b1;
    wait_until(tc + 2 + DEB);
    check("step_pre_mode", 32'(mode), 32'd0);
    wait_until(tc + 3 + DEB);
    check("step_mode", 32'(mode), 32'd2);
    wait_until(tc + 4 + DEB);
    check("step_post_mode", 32'(mode), 32'd0);
    wait_until(tc + 10);
    step_btn = 1'b0;
    repeat (DEB + 8) @(negedge clk);
    check("cnt_after_step", cycle_cnt, exp_cnt);
  endtask

  // halt request exactly on a due pulse at the slowest rate
  task automatic halt_test();
    int c, e;
    c = cyc;
    e = c + 3;
    push(e + 8, 2'b01);
    run_sw = 1'b1;
    speed_sel = 2'd3;
    wait_until(e + 15);
    halt_req = 1'b1;
    wait_until(e + 16);
    halt_req = 1'b0;
    check("halt_mode", 32'(mode), 32'd0);
    wait_until(e + 26);
    check("halt_locked_mode", 32'(mode), 32'd0);
    run_sw = 1'b0;
    wait_until(e + 31);
    check("cnt_after_halt", cycle_cnt, exp_cnt);
  endtask

  // slow select with tick at 6, then switch to select 1: fires immediately
  task automatic rate_test();
    int c, e;
    c = cyc;
    e = c + 3;
    for (int t = e + 7; t <= c + 27; t += 4) push(t, 2'b01);
    run_sw = 1'b1;
    speed_sel = 2'd3;
    wait_until(e + 4);
    speed_sel = 2'd1;
    wait_until(c + 25);
    run_sw = 1'b0;
    wait_until(c + 28);
    check("rate_exit_mode", 32'(mode), 32'd0);
    wait_until(c + 30);
    check("cnt_after_rate", cycle_cnt, exp_cnt);
  endtask

  // synchronous reset on a pulse-due cycle, run switch kept on
  task automatic reset_test();
    int c, e;
    c = cyc;
    e = c + 3;
    push(e + 4, 2'b01);
    run_sw = 1'b1;
    speed_sel = 2'd1;
    wait_until(e + 7);
    rst_n = 1'b0;
    wait_until(e + 8);
    check("rst_ce", 32'(cpu_ce), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_cnt", cycle_cnt, 32'd0);
    exp_cnt = 32'd0;
    push(e + 15, 2'b01);
    push(e + 19, 2'b01);
    rst_n = 1'b1;
    wait_until(e + 10);
    check("rst_reentry_pre", 32'(mode), 32'd0);
    wait_until(e + 11);
    check("rst_reentry_mode", 32'(mode), 32'd1);
    wait_until(e + 20);
    run_sw = 1'b0;
    wait_until(e + 23);
    check("rst_exit_mode", 32'(mode), 32'd0);
    wait_until(e + 25);
    check("cnt_after_rst", cycle_cnt, exp_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    run_sw = 1'b0;
    step_btn = 1'b0;
    speed_sel = 2'd0;
    halt_req = 1'b0;
    exp_cnt = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_ce", 32'(cpu_ce), 32'd0);
    check("reset_mode", 32'(mode), 32'd0);
    check("reset_cnt", cycle_cnt, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_seg(1, 30);
    run_seg(0, 10);
    step_seg(2);
    halt_test();
    run_seg(3, 20);
    rate_test();
    reset_test();

    force dut.cycle_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cycle_cnt;
    @(negedge clk);
    exp_cnt = 32'hFFFF_FFFF;
    check("wrap_preload", cycle_cnt, exp_cnt);
    step_seg(0);

    for (int i = 0; i < 6; i++) run_seg($urandom_range(0, 3), $urandom_range(8, 40));
    for (int i = 0; i < 2; i++) step_seg(0);

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
